rf_write_scheduler: RTL and testbench

//  Write-side initiator for the 3-read/3-write register RAM: buffers writeback results in a circular queue.

---
 rtl/rf_wb_pkg.sv | 44 ++++
 rtl/rf_write_scheduler_queue.sv | 76 +++++++
 rtl/rf_write_scheduler.sv | 101 ++++++++++
 tb/tb_rf_write_scheduler.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// Shared types and drain-group selection for the register-file write scheduler.
// Group policy depends on WB_COALESCE_EN (coalesce same-address writes instead of truncating).
package rf_wb_pkg;

  localparam int unsigned NUM_WR_PORTS      = 3;
  localparam int unsigned OPRAND_WIDTH_DEF  = 8;
  localparam int unsigned REGNAME_WIDTH_DEF = 5;

  typedef struct packed {
    logic [REGNAME_WIDTH_DEF-1:0] addr;
    logic [OPRAND_WIDTH_DEF-1:0]  data;
  } wb_entry_t;

  typedef struct packed {
    logic [NUM_WR_PORTS-1:0] en;
    logic [1:0]              pop;
  } grp_sel_t;

  // avail = min(count,3); eqXY = address of head+X equals address of head+Y.
  function automatic grp_sel_t group_select(input logic [1:0] avail,
                                            input logic eq01,
                                            input logic eq02,
                                            input logic eq12);
    grp_sel_t   r;
    logic [1:0] n;
    n = avail;
`ifdef WB_COALESCE_EN
    r.en[0] = (n >= 2'd1) && !((n >= 2'd2) && eq01) && !((n == 2'd3) && eq02);
    r.en[1] = (n >= 2'd2) && !((n == 2'd3) && eq12);
    r.en[2] = (n == 2'd3);
`else
    if ((n >= 2'd2) && eq01)
      n = 2'd1;
    else if ((n == 2'd3) && (eq02 || eq12))
      n = 2'd2;
    r.en[0] = (n >= 2'd1);
    r.en[1] = (n >= 2'd2);
    r.en[2] = (n == 2'd3);
`endif
    r.pop = n;
    return r;
  endfunction

endpackage

// File: rtl/rf_write_scheduler_queue.sv
// Circular writeback queue: 3-lane compacting push, up to 3 pops per cycle, flush.
module rf_wb_queue
  import rf_wb_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_en,
  input  logic [NUM_WR_PORTS-1:0] lane_valid,
  input  logic [ADDR_W-1:0]       lane_addr [NUM_WR_PORTS],
  input  logic [DATA_W-1:0]       lane_data [NUM_WR_PORTS],
  input  logic [1:0]              pop_cnt,
  input  logic                    flush,
  output logic [ADDR_W-1:0]       head_addr [NUM_WR_PORTS],
  output logic [DATA_W-1:0]       head_data [NUM_WR_PORTS],
  output logic [PTR_W:0]          count
);

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [PTR_W-1:0]  slot_ptr [NUM_WR_PORTS];
  logic [1:0]        push_cnt;
  logic              push_go;

  assign push_go = push_en && !flush;

  // Each valid lane lands after all earlier valid lanes, so gaps are squeezed out.
  always_comb begin
    logic [1:0] off;
    off = '0;
    for (int unsigned k = 0; k < NUM_WR_PORTS; k++) begin
      slot_ptr[k] = tail + PTR_W'(off);
      if (push_go && lane_valid[k])
        off = off + 2'd1;
    end
    push_cnt = off;
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < NUM_WR_PORTS; k++) begin
      if (push_go && lane_valid[k]) begin
        mem_addr[slot_ptr[k]] <= lane_addr[k];
        mem_data[slot_ptr[k]] <= lane_data[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop_cnt);
      tail  <= tail + PTR_W'(push_cnt);
      count <= count + (PTR_W+1)'(push_cnt) - (PTR_W+1)'(pop_cnt);
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < NUM_WR_PORTS; j++) begin
      head_addr[j] = mem_addr[head + PTR_W'(j)];
      head_data[j] = mem_data[head + PTR_W'(j)];
    end
  end

endmodule

// File: rtl/rf_write_scheduler.sv
// Writeback queue front-end issuing up to 3 conflict-free RAM writes per cycle, oldest first.
// Define WB_COALESCE_EN to drop superseded same-address writes instead of truncating the group.
module rf_write_scheduler
  import rf_wb_pkg::*;
#(
  parameter int unsigned OPRAND_WIDTH  = 8,
  parameter int unsigned REGNAME_WIDTH = 5,
  parameter int unsigned QUEUE_DEPTH   = 8,
  parameter int unsigned PTR_WIDTH     = $clog2(QUEUE_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq1_valid_i,
  input  logic [REGNAME_WIDTH-1:0] enq1_addr_i,
  input  logic [OPRAND_WIDTH-1:0]  enq1_data_i,
  input  logic                     enq2_valid_i,
  input  logic [REGNAME_WIDTH-1:0] enq2_addr_i,
  input  logic [OPRAND_WIDTH-1:0]  enq2_data_i,
  input  logic                     enq3_valid_i,
  input  logic [REGNAME_WIDTH-1:0] enq3_addr_i,
  input  logic [OPRAND_WIDTH-1:0]  enq3_data_i,
  output logic                     enq_ready_o,
  input  logic                     drain_en_i,
  input  logic                     flush_i,
  output logic                     write1_en_o,
  output logic [REGNAME_WIDTH-1:0] write1_addr_o,
  output logic [OPRAND_WIDTH-1:0]  write1_data_o,
  output logic                     write2_en_o,
  output logic [REGNAME_WIDTH-1:0] write2_addr_o,
  output logic [OPRAND_WIDTH-1:0]  write2_data_o,
  output logic                     write3_en_o,
  output logic [REGNAME_WIDTH-1:0] write3_addr_o,
  output logic [OPRAND_WIDTH-1:0]  write3_data_o,
  output logic [PTR_WIDTH:0]       count_o,
  output logic                     empty_o
);

  logic [NUM_WR_PORTS-1:0]  lane_valid;
  logic [REGNAME_WIDTH-1:0] lane_addr [NUM_WR_PORTS];
  logic [OPRAND_WIDTH-1:0]  lane_data [NUM_WR_PORTS];
  logic [REGNAME_WIDTH-1:0] head_addr [NUM_WR_PORTS];
  logic [OPRAND_WIDTH-1:0]  head_data [NUM_WR_PORTS];
  logic [PTR_WIDTH:0]       count;
  logic [1:0]               avail;
  logic                     issue;
  grp_sel_t                 grp;
  logic [NUM_WR_PORTS-1:0]  wr_en;
  logic [1:0]               pop_cnt;

  assign lane_valid   = {enq3_valid_i, enq2_valid_i, enq1_valid_i};
  assign lane_addr[0] = enq1_addr_i;
  assign lane_addr[1] = enq2_addr_i;
  assign lane_addr[2] = enq3_addr_i;
  assign lane_data[0] = enq1_data_i;
  assign lane_data[1] = enq2_data_i;
  assign lane_data[2] = enq3_data_i;

  // Ready depends only on the registered count, so there is no enq->ready path.
  assign enq_ready_o = (count <= (PTR_WIDTH+1)'(QUEUE_DEPTH - NUM_WR_PORTS));
  assign count_o     = count;
  assign empty_o     = (count == '0);

  rf_wb_queue #(
    .DATA_W (OPRAND_WIDTH),
    .ADDR_W (REGNAME_WIDTH),
    .DEPTH  (QUEUE_DEPTH),
    .PTR_W  (PTR_WIDTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push_en    (enq_ready_o),
    .lane_valid (lane_valid),
    .lane_addr  (lane_addr),
    .lane_data  (lane_data),
    .pop_cnt    (pop_cnt),
    .flush      (flush_i),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .count      (count)
  );

  assign avail = (count >= (PTR_WIDTH+1)'(NUM_WR_PORTS)) ? 2'd3 : count[1:0];
  assign grp   = group_select(avail,
                              head_addr[0] == head_addr[1],
                              head_addr[0] == head_addr[2],
                              head_addr[1] == head_addr[2]);
  assign issue   = drain_en_i && !flush_i;
  assign wr_en   = issue ? grp.en : '0;
  assign pop_cnt = issue ? grp.pop : 2'd0;

  assign write1_en_o   = wr_en[0];
  assign write1_addr_o = wr_en[0] ? head_addr[0] : '0;
  assign write1_data_o = wr_en[0] ? head_data[0] : '0;
  assign write2_en_o   = wr_en[1];
  assign write2_addr_o = wr_en[1] ? head_addr[1] : '0;
  assign write2_data_o = wr_en[1] ? head_data[1] : '0;
  assign write3_en_o   = wr_en[2];
  assign write3_addr_o = wr_en[2] ? head_addr[2] : '0;
  assign write3_data_o = wr_en[2] ? head_data[2] : '0;

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed + randomized bench for rf_write_scheduler against a queue-level reference model.
// Model follows WB_COALESCE_EN when the macro is defined for the build.
module tb_rf_write_scheduler;
  import rf_wb_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enq1_valid_i = 1'b0, enq2_valid_i = 1'b0, enq3_valid_i = 1'b0;
  logic [4:0] enq1_addr_i = '0, enq2_addr_i = '0, enq3_addr_i = '0;
  logic [7:0] enq1_data_i = '0, enq2_data_i = '0, enq3_data_i = '0;
  logic       drain_en_i = 1'b0, flush_i = 1'b0;
  logic       enq_ready_o, empty_o;
  logic       write1_en_o, write2_en_o, write3_en_o;
  logic [4:0] write1_addr_o, write2_addr_o, write3_addr_o;
  logic [7:0] write1_data_o, write2_data_o, write3_data_o;
  logic [3:0] count_o;

  int unsigned total = 0, passed = 0, failed = 0;
  wb_entry_t   q[$];
  logic [7:0]  ram_exp [32];
  logic [7:0]  ram_obs [32];

  always #5 clk = ~clk;

  rf_write_scheduler #(
    .OPRAND_WIDTH  (8),
    .REGNAME_WIDTH (5),
    .QUEUE_DEPTH   (8)
  ) dut (
    .clk (clk), .rst (rst),
    .enq1_valid_i (enq1_valid_i), .enq1_addr_i (enq1_addr_i), .enq1_data_i (enq1_data_i),
    .enq2_valid_i (enq2_valid_i), .enq2_addr_i (enq2_addr_i), .enq2_data_i (enq2_data_i),
    .enq3_valid_i (enq3_valid_i), .enq3_addr_i (enq3_addr_i), .enq3_data_i (enq3_data_i),
    .enq_ready_o (enq_ready_o), .drain_en_i (drain_en_i), .flush_i (flush_i),
    .write1_en_o (write1_en_o), .write1_addr_o (write1_addr_o), .write1_data_o (write1_data_o),
    .write2_en_o (write2_en_o), .write2_addr_o (write2_addr_o), .write2_data_o (write2_data_o),
    .write3_en_o (write3_en_o), .write3_addr_o (write3_addr_o), .write3_data_o (write3_data_o),
    .count_o (count_o), .empty_o (empty_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] port_obs(input int j);
    case (j)
      0:       return {write1_en_o, write1_addr_o, write1_data_o};
      1:       return {write2_en_o, write2_addr_o, write2_data_o};
      default: return {write3_en_o, write3_addr_o, write3_data_o};
    endcase
  endfunction

  // Called at a falling edge; drives inputs, checks this cycle, then advances the model one edge.
  task automatic step(input string tag, input logic [2:0] v, input logic [2:0][4:0] a,
                      input logic [2:0][7:0] d, input logic drain, input logic fl);
    logic [2:0]  exp_en;
    logic [13:0] exp_port, obs_port;
    int          n, pop;
    bit          ready, stop, dup;
    {enq3_valid_i, enq2_valid_i, enq1_valid_i} = v;
    enq1_addr_i = a[0]; enq2_addr_i = a[1]; enq3_addr_i = a[2];
    enq1_data_i = d[0]; enq2_data_i = d[1]; enq3_data_i = d[2];
    drain_en_i = drain;
    flush_i    = fl;
    #1;
    n      = (q.size() < 3) ? q.size() : 3;
    ready  = (8 - q.size()) >= 3;
    exp_en = '0;
    pop    = 0;
    if (drain && !fl) begin
`ifdef WB_COALESCE_EN
      pop = n;
      for (int i = 0; i < n; i++) begin
        exp_en[i] = 1'b1;
        for (int k = i + 1; k < n; k++)
          if (q[k].addr == q[i].addr) exp_en[i] = 1'b0;
      end
`else
      stop = 1'b0;
      for (int i = 0; i < n; i++) begin
        dup = 1'b0;
        for (int k = 0; k < i; k++)
          if (q[k].addr == q[i].addr) dup = 1'b1;
        if (dup) stop = 1'b1;
        if (!stop) begin
          exp_en[i] = 1'b1;
          pop++;
        end
      end
`endif
    end
    for (int j = 0; j < 3; j++) begin
      exp_port = exp_en[j] ? {1'b1, q[j].addr, q[j].data} : 14'd0;
      obs_port = port_obs(j);
      chk($sformatf("%s.wr%0d", tag, j + 1), 32'(obs_port), 32'(exp_port));
      if (exp_en[j]) ram_exp[q[j].addr] = q[j].data;
      if (obs_port[13]) ram_obs[obs_port[12:8]] = obs_port[7:0];
    end
    chk({tag, ".count"}, 32'(count_o), 32'(q.size()));
    chk({tag, ".empty"}, 32'(empty_o), 32'(q.size() == 0));
    chk({tag, ".ready"}, 32'(enq_ready_o), 32'(ready));
    @(posedge clk);
    if (fl) q.delete();
    else begin
      repeat (pop) void'(q.pop_front());
      if (ready)
        for (int k = 0; k < 3; k++)
          if (v[k]) q.push_back('{addr: a[k], data: d[k]});
    end
    @(negedge clk);
  endtask

  task automatic idle(input string tag, input logic drain);
    step(tag, 3'b000, '0, '0, drain, 1'b0);
  endtask

  initial begin
    logic [2:0]      v;
    logic [2:0][4:0] a;
    logic [2:0][7:0] d;
    int              idx, nxt, guard;

    for (int i = 0; i < 32; i++) begin
      ram_exp[i] = '0;
      ram_obs[i] = '0;
    end

    // Reset state
    #1;
    chk("rst.en",    32'({write1_en_o, write2_en_o, write3_en_o}), 32'd0);
    chk("rst.count", 32'(count_o), 32'd0);
    chk("rst.ready", 32'(enq_ready_o), 32'd1);
    chk("rst.empty", 32'(empty_o), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // 1: sparse lanes compact into consecutive ports
    step("t1.push", 3'b101, {5'd9, 5'd0, 5'd4}, {8'h22, 8'h00, 8'h11}, 1'b1, 1'b0);
    idle("t1.drain", 1'b1);
    idle("t1.after", 1'b1);

    // 2: same-address collision inside one group
    step("t2.push", 3'b111, {5'd7, 5'd5, 5'd5}, {8'hCC, 8'hBB, 8'hAA}, 1'b1, 1'b0);
    idle("t2.c1", 1'b1);
    idle("t2.c2", 1'b1);
    idle("t2.c3", 1'b1);

    // 3: fill to backpressure with drain held off; ignored pushes must not be stored
    step("t3.p1", 3'b111, {5'd12, 5'd11, 5'd10}, {8'h03, 8'h02, 8'h01}, 1'b0, 1'b0);
    step("t3.p2", 3'b111, {5'd15, 5'd14, 5'd13}, {8'h06, 8'h05, 8'h04}, 1'b0, 1'b0);
    step("t3.nr", 3'b111, {5'd18, 5'd17, 5'd16}, {8'hF3, 8'hF2, 8'hF1}, 1'b0, 1'b0);
    idle("t3.d1", 1'b1);
    idle("t3.d2", 1'b1);
    idle("t3.d3", 1'b1);

    // 5: flush with count=5 and valid lanes
    step("t5.p1", 3'b111, {5'd3, 5'd2, 5'd1}, {8'h33, 8'h22, 8'h11}, 1'b0, 1'b0);
    step("t5.p2", 3'b011, {5'd0, 5'd5, 5'd4}, {8'h00, 8'h55, 8'h44}, 1'b0, 1'b0);
    step("t5.fl", 3'b111, {5'd8, 5'd7, 5'd6}, {8'h88, 8'h77, 8'h66}, 1'b1, 1'b1);
    idle("t5.post", 1'b1);

    // Random collision-heavy traffic on a tiny address range
    for (int c = 0; c < 60; c++) begin
      v = 3'($urandom_range(0, 7));
      for (int k = 0; k < 3; k++) begin
        a[k] = 5'($urandom_range(0, 3));
        d[k] = 8'($urandom);
      end
      step("rnd", v, a, d, ($urandom_range(0, 3) != 0), 1'b0);
    end
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      idle("rnd.drain", 1'b1);
      guard++;
    end
    chk("rnd.empty", 32'(count_o), 32'd0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rnd.ram%0d", i), 32'(ram_obs[i]), 32'(ram_exp[i]));

    // 4: stream 24 entries with random drain; pointers wrap several times
    idx   = 0;
    guard = 0;
    while (idx < 24 && guard < 300) begin
      v   = 3'($urandom_range(0, 7));
      nxt = idx;
      for (int k = 0; k < 3; k++) begin
        if (v[k] && nxt < 24) begin
          a[k] = 5'(nxt % 32);
          d[k] = 8'(nxt);
          nxt++;
        end else begin
          v[k] = 1'b0;
          a[k] = '0;
          d[k] = '0;
        end
      end
      if ((8 - q.size()) >= 3) idx = nxt;
      step("t4.s", v, a, d, ($urandom_range(0, 1) != 0), 1'b0);
      guard++;
    end
    chk("t4.pushed", 32'(idx), 32'd24);
    guard = 0;
    while (q.size() != 0 && guard < 30) begin
      idle("t4.drain", 1'b1);
      guard++;
    end
    chk("t4.empty", 32'(count_o), 32'd0);
    for (int i = 0; i < 24; i++)
      chk($sformatf("t4.ram%0d", i), 32'(ram_obs[i]), 32'(i));

    // 6: asynchronous reset mid-stream with count=4
    step("t6.p1", 3'b111, {5'd22, 5'd21, 5'd20}, {8'hA2, 8'hA1, 8'hA0}, 1'b0, 1'b0);
    step("t6.p2", 3'b001, {5'd0, 5'd0, 5'd23}, {8'h00, 8'h00, 8'hA3}, 1'b0, 1'b0);
    {enq3_valid_i, enq2_valid_i, enq1_valid_i} = 3'b000;
    drain_en_i = 1'b1;
    #1;
    chk("t6.count4", 32'(count_o), 32'd4);
    chk("t6.pre.wr1", 32'(port_obs(0)), 32'({1'b1, 5'd20, 8'hA0}));
    rst = 1'b1;
    #1;
    chk("t6.rst.en", 32'({write1_en_o, write2_en_o, write3_en_o}), 32'd0);
    chk("t6.rst.count", 32'(count_o), 32'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    idle("t6.post", 1'b1);
    step("t6.re", 3'b010, {5'd0, 5'd30, 5'd0}, {8'h00, 8'h5A, 8'h00}, 1'b1, 1'b0);
    idle("t6.re.d", 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
